// File: rtl/sif_stream_fifo.sv
// SIF valid/ready stream FIFO: circular buffer between the up (sink) and dn (source) streams.
// Optional push/pop statistics counters are built when SIF_STAT_EN is defined.
module sif_stream_fifo #(
  parameter int unsigned DMA_WIDTH = 32,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       up_vld,
  input  logic [DMA_WIDTH-1:0]       up_dat,
  output logic                       up_rdy,
  output logic                       dn_vld,
  output logic [DMA_WIDTH-1:0]       dn_dat,
  input  logic                       dn_rdy,
`ifdef SIF_STAT_EN
  output logic [31:0]                stat_in,
  output logic [31:0]                stat_out,
`endif
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthL = (AW+1)'(DEPTH);

  logic [DMA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        up_rdy_q, up_rdy_d;
  logic        empty, full;
  logic        push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign push = up_vld & up_rdy_q & ~full;
  assign pop  = dn_vld & dn_rdy;

  assign up_rdy = up_rdy_q;
  assign dn_vld = ~empty;
  assign dn_dat = dn_vld ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign level  = level_q;

  // DEPTH is a power of two, so a plain increment wraps the index and toggles the MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    level_d  = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    up_rdy_d = (level_d < DepthL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      up_rdy_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      up_rdy_q <= up_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= up_dat;
  end

`ifdef SIF_STAT_EN
  logic [31:0] stat_in_q, stat_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else begin
      if (push) stat_in_q  <= stat_in_q + 32'd1;
      if (pop)  stat_out_q <= stat_out_q + 32'd1;
    end
  end

  assign stat_in  = stat_in_q;
  assign stat_out = stat_out_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(up_vld)) else $error("sif_stream_fifo: up_vld is X");
      assert (!$isunknown(dn_rdy)) else $error("sif_stream_fifo: dn_rdy is X");
    end
  end
`endif

endmodule

// File: tb/tb_sif_stream_fifo.sv
// Randomised scoreboard bench for sif_stream_fifo: directed reset/latency/full cases
// followed by a 1000-word random stream checked against a queue model.
module tb_sif_stream_fifo;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk;
  logic          rst_n;
  logic          up_vld;
  logic [W-1:0]  up_dat;
  logic          up_rdy;
  logic          dn_vld;
  logic [W-1:0]  dn_dat;
  logic          dn_rdy;
  logic [4:0]    level;
`ifdef SIF_STAT_EN
  logic [31:0]   stat_in;
  logic [31:0]   stat_out;
`endif

  sif_stream_fifo #(.DMA_WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_vld   (up_vld),
    .up_dat   (up_dat),
    .up_rdy   (up_rdy),
    .dn_vld   (dn_vld),
    .dn_dat   (dn_dat),
    .dn_rdy   (dn_rdy),
`ifdef SIF_STAT_EN
    .stat_in  (stat_in),
    .stat_out (stat_out),
`endif
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q [$];
  int n_acc = 0;
  int n_del = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Recorder: any word that will be taken on the coming edge is expected later on dn.
  always @(negedge clk) begin
    if (rst_n && up_vld && up_rdy) begin
      exp_q.push_back(up_dat);
      n_acc++;
    end
  end

  // Monitor: compare each delivered word against the head of the model queue.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_dat   = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_vld", {31'd0, dn_vld}, 32'd1);
        check("stall_dat", dn_dat, prev_dat);
      end
      if (dn_vld && dn_rdy) begin
        if (exp_q.size() == 0) begin
          check("pop_on_empty_model", 32'd1, 32'd0);
        end else begin
          check("dn_dat", dn_dat, exp_q[0]);
          void'(exp_q.pop_front());
        end
        n_del++;
      end
    end
    prev_stall = rst_n && dn_vld && !dn_rdy;
    prev_dat   = dn_dat;
  end

  // Occupancy checker: level and flags follow the count of words in flight.
  always @(posedge clk) begin
    #3;
    if (rst_n) begin
      check("level", {27'd0, level}, 32'(n_acc - n_del));
      check("dn_vld_flag", {31'd0, dn_vld}, {31'd0, (n_acc != n_del)});
      check("up_rdy_flag", {31'd0, up_rdy}, {31'd0, ((n_acc - n_del) < D)});
    end
  end

  task automatic wait_empty(input string nm, input int budget);
    int k = 0;
    while (level != 0 && k < budget) begin
      tick();
      k++;
    end
    check(nm, {27'd0, level}, 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    int acc0;
    rst_n  = 1'b0;
    up_vld = 1'b0;
    up_dat = '0;
    dn_rdy = 1'b0;

    #2;
    check("rst_dn_vld", {31'd0, dn_vld}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_up_rdy", {31'd0, up_rdy}, 32'd0);
    #20;
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", {31'd0, up_rdy}, 32'd0);
    tick();
    check("rdy_after_edge", {31'd0, up_rdy}, 32'd1);

    // Latency: one word through an empty FIFO.
    up_vld = 1'b1;
    up_dat = 32'hA5A5_0001;
    dn_rdy = 1'b1;
    tick();
    up_vld = 1'b0;
    check("lat_vld", {31'd0, dn_vld}, 32'd1);
    check("lat_dat", dn_dat, 32'hA5A5_0001);
    tick();
    check("lat_popped", {31'd0, dn_vld}, 32'd0);

    // Fill to full with the sink stalled.
    dn_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      up_vld = 1'b1;
      up_dat = 32'(i);
      tick();
    end
    up_dat = 32'h11;
    check("full_level", {27'd0, level}, 32'd16);
    check("full_rdy", {31'd0, up_rdy}, 32'd0);
    repeat (3) tick();
    check("full_hold_level", {27'd0, level}, 32'd16);

    // One pop at full, then the held word goes in.
    dn_rdy = 1'b1;
    tick();
    dn_rdy = 1'b0;
    check("after_pop_rdy", {31'd0, up_rdy}, 32'd1);
    check("after_pop_level", {27'd0, level}, 32'd15);
    tick();
    up_vld = 1'b0;
    check("refill_level", {27'd0, level}, 32'd16);
    dn_rdy = 1'b1;
    wait_empty("drain_full", 40);
    check("drain_count", 32'(n_del), 32'(n_acc));

    // Asynchronous reset mid-cycle with five words buffered.
    dn_rdy = 1'b0;
    up_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_dat = 32'hBEEF_0000 + 32'(i);
      tick();
    end
    up_vld = 1'b0;
    check("pre_rst_level", {27'd0, level}, 32'd5);
    #1;
    rst_n = 1'b0;
    #2;
    check("midrst_dn_vld", {31'd0, dn_vld}, 32'd0);
    check("midrst_level", {27'd0, level}, 32'd0);
    check("midrst_up_rdy", {31'd0, up_rdy}, 32'd0);
    exp_q.delete();
    n_acc = 0;
    n_del = 0;
    #13;
    rst_n = 1'b1;
    #1;
    check("midrst_rdy_low", {31'd0, up_rdy}, 32'd0);
    tick();
    check("midrst_rdy_high", {31'd0, up_rdy}, 32'd1);

    // Random stream of 1000 words with 50% valid/ready.
    sent = 0;
    cyc  = 0;
    up_vld = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!up_vld) begin
        up_vld = 1'($urandom_range(0, 1));
        up_dat = $urandom;
      end
      dn_rdy = 1'($urandom_range(0, 1));
      acc0 = n_acc;
      tick();
      cyc++;
      if (n_acc != acc0) begin
        sent++;
        up_vld = 1'b0;
        if (sent < 1000) begin
          up_vld = 1'($urandom_range(0, 1));
          up_dat = $urandom;
        end
      end
    end
    up_vld = 1'b0;
    check("stream_sent", 32'(sent), 32'd1000);
    dn_rdy = 1'b1;
    wait_empty("stream_drain", 100);
    check("stream_acc", 32'(n_acc), 32'd1000);
    check("stream_del", 32'(n_del), 32'd1000);

`ifdef SIF_STAT_EN
    check("stat_in", stat_in, 32'd1000);
    check("stat_out", stat_out, 32'd1000);
    force dut.stat_in_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_in_q;
    up_vld = 1'b1;
    up_dat = 32'h1234_5678;
    tick();
    up_vld = 1'b0;
    check("stat_wrap", stat_in, 32'd0);
    wait_empty("stat_drain", 20);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
